wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Writeback queue: buffers MEM/ALU register writes and drains one per cycle to RF port 1.
// Optional feature: define WBQ_FORWARD_EN for youngest-match data forwarding outputs.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_wb_valid,
    input  logic [3:0]               mem_wb_ws,
    input  logic [31:0]              mem_wb_wd,
    input  logic                     alu_wb_valid,
    input  logic [3:0]               alu_wb_ws,
    input  logic [31:0]              alu_wb_wd,
    input  logic                     drain_en,
    output logic                     wbq_stall,
    output logic [3:0]               rf_ws1,
    output logic [31:0]              rf_wd1,
    output logic                     rf_we1,
    output logic                     do_write1,
    input  logic [3:0]               rf_rs1,
    input  logic [3:0]               rf_rs2,
    input  logic [3:0]               rf_rs3,
    output logic                     wbq_hit1,
    output logic                     wbq_hit2,
    output logic                     wbq_hit3,
`ifdef WBQ_FORWARD_EN
    output logic [31:0]              wbq_fwd_d1,
    output logic [31:0]              wbq_fwd_d2,
    output logic [31:0]              wbq_fwd_d3,
`endif
    output logic [$clog2(DEPTH):0]   wbq_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]  ws;
        logic [31:0] wd;
    } wb_ent_t;

    wb_ent_t       ent_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
    logic [CW-1:0] count_q, count_d;
    logic          enq_mem, enq_alu, deq;

    logic [2:0][3:0]  rs_sel;
    logic [2:0]       hit;
`ifdef WBQ_FORWARD_EN
    logic [2:0][31:0] fwd;
`endif
    logic [PW-1:0]    idx;

    always_comb begin
        // Stall needs 2 free slots so both producers can always be accepted together.
        wbq_stall = !reset && (count_q > CW'(DEPTH - 2));
        enq_mem   = mem_wb_valid && !wbq_stall;
        enq_alu   = alu_wb_valid && !wbq_stall;
        deq       = !reset && (count_q != '0) && drain_en;
        alu_slot  = enq_mem ? tail_q + PW'(1) : tail_q;
        tail_d    = tail_q + PW'(enq_mem) + PW'(enq_alu);
        head_d    = head_q + PW'(deq);
        count_d   = count_q + CW'(enq_mem) + CW'(enq_alu) - CW'(deq);

        rf_we1    = deq;
        do_write1 = deq;
        rf_ws1    = deq ? ent_q[head_q].ws : '0;
        rf_wd1    = deq ? ent_q[head_q].wd : '0;
        wbq_count = count_q;
    end

    // Walk oldest to youngest so a later match overrides: forward data ends up youngest.
    always_comb begin
        rs_sel = {rf_rs3, rf_rs2, rf_rs1};
        hit    = '0;
`ifdef WBQ_FORWARD_EN
        fwd    = '0;
`endif
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (!reset && (CW'(k) < count_q)) begin
                for (int p = 0; p < 3; p++) begin
                    if (ent_q[idx].ws == rs_sel[p]) begin
                        hit[p] = 1'b1;
`ifdef WBQ_FORWARD_EN
                        fwd[p] = ent_q[idx].wd;
`endif
                    end
                end
            end
        end
        wbq_hit1 = hit[0];
        wbq_hit2 = hit[1];
        wbq_hit3 = hit[2];
    end

`ifdef WBQ_FORWARD_EN
    assign wbq_fwd_d1 = fwd[0];
    assign wbq_fwd_d2 = fwd[1];
    assign wbq_fwd_d3 = fwd[2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_mem) ent_q[tail_q]   <= '{ws: mem_wb_ws, wd: mem_wb_wd};
        if (enq_alu) ent_q[alu_slot] <= '{ws: alu_wb_ws, wd: alu_wb_wd};
    end
endmodule
